sprite_command_sink: RTL and testbench

SPRITE_COMMAND_SINK -- requirements
Module: sprite_command_sink

---
 rtl/sprite_command_sink_pkg.sv | 24 ++
 rtl/sprite_command_sink_if.sv | 26 ++
 rtl/sprite_command_sink_command_fifo.sv | 52 +++++
 rtl/sprite_command_sink.sv | 212 +++++++++++++++++++++
 tb/tb_sprite_command_sink.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_command_sink_pkg.sv
// Shared definitions for the sprite command path: opcodes, default coordinate width,
// and the consumer FSM state type.
package sprite_command_sink_pkg;

  localparam int unsigned COORD_WIDTH_DEFAULT = 10;

  localparam logic [4:0] OP_SPRITE_LEVEL = 5'b00001;
  localparam logic [4:0] OP_SPRITE_POS   = 5'b00010;
  localparam logic [4:0] OP_PUT_IMAGE    = 5'b00101;
  localparam logic [4:0] OP_WAIT_VSYNC   = 5'b00110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WAIT,
    ST_COMMIT
  } sink_state_t;

  // Packed command layout: {opcode, sprite_id, x, y, aux}
  function automatic int unsigned cmd_width(input int unsigned coord_width);
    return 5 + 5 + 2 * coord_width + 2;
  endfunction

endpackage

// File: rtl/sprite_command_sink_if.sv
// Processor-to-sink command handshake bundle.
interface sprite_command_sink_if
  import sprite_command_sink_pkg::*;
#(
  parameter int unsigned COORD_WIDTH = COORD_WIDTH_DEFAULT
);

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [4:0]             cmd_opcode;
  logic [4:0]             cmd_sprite_id;
  logic [COORD_WIDTH-1:0] cmd_x;
  logic [COORD_WIDTH-1:0] cmd_y;
  logic [1:0]             cmd_aux;

  modport master (
    output cmd_valid, cmd_opcode, cmd_sprite_id, cmd_x, cmd_y, cmd_aux,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_sprite_id, cmd_x, cmd_y, cmd_aux,
    output cmd_ready
  );

endinterface

// File: rtl/sprite_command_sink_command_fifo.sv
// CommandFifo: power-of-two deep command queue with registered occupancy count.
module sprite_command_sink_command_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers are AW bits wide, so increments wrap modulo DEPTH on their own
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sprite_command_sink.sv
// Sprite command sink: queues processor commands, applies them to a shadow sprite bank,
// and commits shadow to the renderer-visible bank on WAIT_VSYNC + vsync.
module sprite_command_sink
  import sprite_command_sink_pkg::*;
#(
  parameter int unsigned SPRITE_COUNT = 32,
  parameter int unsigned COORD_WIDTH  = COORD_WIDTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  sprite_command_sink_if.slave   cmd,
  input  logic                   vsync,
  output logic                   vsync_done,
  input  logic [4:0]             rd_id,
  output logic [COORD_WIDTH-1:0] rd_x,
  output logic [COORD_WIDTH-1:0] rd_y,
  output logic                   rd_enable,
  output logic [1:0]             rd_level,
  output logic [COORD_WIDTH-1:0] bg_x,
  output logic [COORD_WIDTH-1:0] bg_y,
  output logic                   bad_cmd
);

  localparam int unsigned CW    = COORD_WIDTH;
  localparam int unsigned IW    = $clog2(SPRITE_COUNT);
  localparam int unsigned CMD_W = cmd_width(COORD_WIDTH);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  logic [CMD_W-1:0] fifo_in;
  logic [CMD_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;
  logic             push;
  logic             pop;

  logic [4:0]    head_op;
  logic [4:0]    head_id;
  logic [CW-1:0] head_x;
  logic [CW-1:0] head_y;
  logic [1:0]    head_aux;
  logic [IW-1:0] head_idx;
  logic          head_id_ok;

  sink_state_t state, state_next;
  logic        exec;
  logic        last_entry;
  logic        wr_pos;
  logic        wr_lvl;
  logic        wr_bg;
  logic        bad_set;
  logic        commit;

  logic [CW-1:0] sh_x   [SPRITE_COUNT];
  logic [CW-1:0] sh_y   [SPRITE_COUNT];
  logic          sh_en  [SPRITE_COUNT];
  logic [1:0]    sh_lvl [SPRITE_COUNT];
  logic [CW-1:0] act_x  [SPRITE_COUNT];
  logic [CW-1:0] act_y  [SPRITE_COUNT];
  logic          act_en [SPRITE_COUNT];
  logic [1:0]    act_lvl[SPRITE_COUNT];
  logic [CW-1:0] sh_bg_x;
  logic [CW-1:0] sh_bg_y;

  logic          rd_ok;
  logic [IW-1:0] rd_idx;

  assign push          = cmd.cmd_valid && !fifo_full;
  assign cmd.cmd_ready = !fifo_full;
  assign fifo_in       = {cmd.cmd_opcode, cmd.cmd_sprite_id, cmd.cmd_x, cmd.cmd_y, cmd.cmd_aux};

  sprite_command_sink_command_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .data_in (fifo_in),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign {head_op, head_id, head_x, head_y, head_aux} = fifo_head;
  assign head_id_ok = (32'(head_id) < SPRITE_COUNT);
  assign head_idx   = head_id[IW-1:0];
  assign last_entry = (fifo_count == (AW+1)'(1)) && !push;
  assign commit     = (state == ST_COMMIT);
  assign vsync_done = commit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // IDLE and EXEC both execute a present head so a command pushed into an empty,
  // idle FIFO reaches the shadow bank on the very next edge.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    exec       = 1'b0;
    case (state)
      ST_IDLE, ST_EXEC: begin
        if (fifo_empty) begin
          state_next = ST_IDLE;
        end else if (head_op == OP_WAIT_VSYNC) begin
          state_next = ST_WAIT;
        end else begin
          pop        = 1'b1;
          exec       = 1'b1;
          state_next = last_entry ? ST_IDLE : ST_EXEC;
        end
      end
      ST_WAIT: begin
        if (vsync) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        pop        = 1'b1;
        state_next = last_entry ? ST_IDLE : ST_EXEC;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_pos  = 1'b0;
    wr_lvl  = 1'b0;
    wr_bg   = 1'b0;
    bad_set = 1'b0;
    if (exec) begin
      case (head_op)
        OP_SPRITE_POS:   begin wr_pos = head_id_ok; bad_set = !head_id_ok; end
        OP_SPRITE_LEVEL: begin wr_lvl = head_id_ok; bad_set = !head_id_ok; end
        OP_PUT_IMAGE:    wr_bg = 1'b1;
        default:         bad_set = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SPRITE_COUNT; i++) begin
        sh_x[i]    <= '0;
        sh_y[i]    <= '0;
        sh_en[i]   <= 1'b0;
        sh_lvl[i]  <= '0;
        act_x[i]   <= '0;
        act_y[i]   <= '0;
        act_en[i]  <= 1'b0;
        act_lvl[i] <= '0;
      end
      sh_bg_x <= '0;
      sh_bg_y <= '0;
      bg_x    <= '0;
      bg_y    <= '0;
      bad_cmd <= 1'b0;
    end else begin
      if (wr_pos) begin
        sh_x[head_idx]  <= head_x;
        sh_y[head_idx]  <= head_y;
        sh_en[head_idx] <= head_aux[0];
      end
      if (wr_lvl) sh_lvl[head_idx] <= head_aux;
      if (wr_bg) begin
        sh_bg_x <= head_x;
        sh_bg_y <= head_y;
      end
      if (bad_set) bad_cmd <= 1'b1;
      if (commit) begin
        act_x   <= sh_x;
        act_y   <= sh_y;
        act_en  <= sh_en;
        act_lvl <= sh_lvl;
        bg_x    <= sh_bg_x;
        bg_y    <= sh_bg_y;
      end
    end
  end

  assign rd_ok  = (32'(rd_id) < SPRITE_COUNT);
  assign rd_idx = rd_id[IW-1:0];

  // During COMMIT the shadow copy is what the active bank becomes at this edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_x      <= '0;
      rd_y      <= '0;
      rd_enable <= 1'b0;
      rd_level  <= '0;
    end else if (!rd_ok) begin
      rd_x      <= '0;
      rd_y      <= '0;
      rd_enable <= 1'b0;
      rd_level  <= '0;
    end else if (commit) begin
      rd_x      <= sh_x[rd_idx];
      rd_y      <= sh_y[rd_idx];
      rd_enable <= sh_en[rd_idx];
      rd_level  <= sh_lvl[rd_idx];
    end else begin
      rd_x      <= act_x[rd_idx];
      rd_y      <= act_y[rd_idx];
      rd_enable <= act_en[rd_idx];
      rd_level  <= act_lvl[rd_idx];
    end
  end

endmodule

// File: tb/tb_sprite_command_sink.sv
// Directed bench for sprite_command_sink: table of command/commit/readback vectors
// plus hand-written sequences for vsync, backpressure, bad commands and reset.
module tb_sprite_command_sink;
  import sprite_command_sink_pkg::*;

  logic       clk;
  logic       reset;
  logic       vsync;
  logic       vsync_done;
  logic [4:0] rd_id;
  logic [9:0] rd_x, rd_y, bg_x, bg_y;
  logic       rd_enable;
  logic [1:0] rd_level;
  logic       bad_cmd;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  sprite_command_sink_if #(.COORD_WIDTH(10)) cmd_bus ();

  sprite_command_sink #(
    .SPRITE_COUNT (16),
    .COORD_WIDTH  (10),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .cmd        (cmd_bus),
    .vsync      (vsync),
    .vsync_done (vsync_done),
    .rd_id      (rd_id),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_enable  (rd_enable),
    .rd_level   (rd_level),
    .bg_x       (bg_x),
    .bg_y       (bg_y),
    .bad_cmd    (bad_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (vsync_done) done_cnt++;

  typedef struct {
    logic [4:0] op;
    logic [4:0] id;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] aux;
    logic [4:0] rid;
    logic [9:0] ex;
    logic [9:0] ey;
    logic       een;
    logic [1:0] elvl;
    logic [9:0] ebx;
    logic [9:0] eby;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] op, input logic [4:0] id, input logic [9:0] x,
                      input logic [9:0] y, input logic [1:0] aux);
    int n;
    @(negedge clk);
    cmd_bus.cmd_valid     = 1'b1;
    cmd_bus.cmd_opcode    = op;
    cmd_bus.cmd_sprite_id = id;
    cmd_bus.cmd_x         = x;
    cmd_bus.cmd_y         = y;
    cmd_bus.cmd_aux       = aux;
    n = 0;
    while (!cmd_bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push timeout", 0, 1);
    @(posedge clk);
    #1 cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic pulse_vsync();
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
  endtask

  task automatic commit(input string tag);
    int  n;
    bit  seen;
    push(OP_WAIT_VSYNC, 5'd0, 10'd0, 10'd0, 2'd0);
    repeat (8) @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    seen = vsync_done;
    n = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      seen = vsync_done;
      n++;
    end
    chk({tag, " vsync_done seen"}, 32'(seen), 1);
    @(negedge clk);
    chk({tag, " vsync_done one cycle"}, 32'(vsync_done), 0);
  endtask

  task automatic rd_check(input string tag, input logic [4:0] id, input logic [9:0] ex,
                          input logic [9:0] ey, input logic een, input logic [1:0] elvl);
    rd_id = id;
    @(negedge clk);
    chk({tag, " rd_x"}, 32'(rd_x), 32'(ex));
    chk({tag, " rd_y"}, 32'(rd_y), 32'(ey));
    chk({tag, " rd_enable"}, 32'(rd_enable), 32'(een));
    chk({tag, " rd_level"}, 32'(rd_level), 32'(elvl));
  endtask

  initial begin
    int c0;

    vecs[0] = '{OP_SPRITE_POS,   5'd3,  10'd100,  10'd50,  2'd1, 5'd3,  10'd100,  10'd50, 1'b1, 2'd0, 10'd0,   10'd0};
    vecs[1] = '{OP_SPRITE_LEVEL, 5'd3,  10'd0,    10'd0,   2'd2, 5'd3,  10'd100,  10'd50, 1'b1, 2'd2, 10'd0,   10'd0};
    vecs[2] = '{OP_SPRITE_POS,   5'd15, 10'd1023, 10'd0,   2'd0, 5'd15, 10'd1023, 10'd0,  1'b0, 2'd0, 10'd0,   10'd0};
    vecs[3] = '{OP_PUT_IMAGE,    5'd0,  10'd640,  10'd480, 2'd0, 5'd3,  10'd100,  10'd50, 1'b1, 2'd2, 10'd640, 10'd480};
    vecs[4] = '{OP_SPRITE_POS,   5'd0,  10'd7,    10'd9,   2'd3, 5'd0,  10'd7,    10'd9,  1'b1, 2'd0, 10'd640, 10'd480};
    vecs[5] = '{OP_SPRITE_LEVEL, 5'd0,  10'd0,    10'd0,   2'd1, 5'd0,  10'd7,    10'd9,  1'b1, 2'd1, 10'd640, 10'd480};
    vecs[6] = '{OP_SPRITE_POS,   5'd3,  10'd5,    10'd6,   2'd0, 5'd3,  10'd5,    10'd6,  1'b0, 2'd2, 10'd640, 10'd480};

    reset = 1'b1;
    vsync = 1'b0;
    rd_id = 5'd0;
    cmd_bus.cmd_valid     = 1'b0;
    cmd_bus.cmd_opcode    = '0;
    cmd_bus.cmd_sprite_id = '0;
    cmd_bus.cmd_x         = '0;
    cmd_bus.cmd_y         = '0;
    cmd_bus.cmd_aux       = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("reset cmd_ready", 32'(cmd_bus.cmd_ready), 1);
    chk("reset vsync_done", 32'(vsync_done), 0);
    chk("reset bad_cmd", 32'(bad_cmd), 0);
    chk("reset bg_x", 32'(bg_x), 0);
    chk("reset bg_y", 32'(bg_y), 0);
    rd_check("reset", 5'd3, 10'd0, 10'd0, 1'b0, 2'd0);

    for (int i = 0; i < 7; i++) begin
      push(vecs[i].op, vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].aux);
      commit($sformatf("vec%0d", i));
      rd_check($sformatf("vec%0d", i), vecs[i].rid, vecs[i].ex, vecs[i].ey, vecs[i].een, vecs[i].elvl);
      chk($sformatf("vec%0d bg_x", i), 32'(bg_x), 32'(vecs[i].ebx));
      chk($sformatf("vec%0d bg_y", i), 32'(bg_y), 32'(vecs[i].eby));
      chk($sformatf("vec%0d bad_cmd", i), 32'(bad_cmd), 0);
    end

    // Active bank must hold old values until the commit pulse
    push(OP_SPRITE_POS, 5'd3, 10'd200, 10'd300, 2'd1);
    push(OP_WAIT_VSYNC, 5'd0, 10'd0, 10'd0, 2'd0);
    repeat (6) @(negedge clk);
    rd_check("pre-commit", 5'd3, 10'd5, 10'd6, 1'b0, 2'd2);
    pulse_vsync();
    chk("commit pulse", 32'(vsync_done), 1);
    @(negedge clk);
    chk("commit pulse ends", 32'(vsync_done), 0);
    rd_check("post-commit", 5'd3, 10'd200, 10'd300, 1'b1, 2'd2);

    // vsync while not waiting is ignored
    c0 = done_cnt;
    push(OP_SPRITE_POS, 5'd1, 10'd11, 10'd12, 2'd1);
    pulse_vsync();
    repeat (4) @(negedge clk);
    push(OP_WAIT_VSYNC, 5'd0, 10'd0, 10'd0, 2'd0);
    repeat (6) @(negedge clk);
    chk("idle vsync no commit", 32'(done_cnt - c0), 0);
    rd_check("idle vsync rd1", 5'd1, 10'd0, 10'd0, 1'b0, 2'd0);
    pulse_vsync();
    repeat (4) @(negedge clk);
    chk("wait vsync one pulse", 32'(done_cnt - c0), 1);
    rd_check("idle vsync rd1 after", 5'd1, 10'd11, 10'd12, 1'b1, 2'd0);

    // Backpressure: WAIT_VSYNC blocks the head, FIFO fills
    push(OP_WAIT_VSYNC, 5'd0, 10'd0, 10'd0, 2'd0);
    push(OP_SPRITE_POS, 5'd4, 10'd40, 10'd41, 2'd1);
    push(OP_SPRITE_POS, 5'd5, 10'd50, 10'd51, 2'd1);
    push(OP_SPRITE_POS, 5'd6, 10'd60, 10'd61, 2'd1);
    @(negedge clk);
    cmd_bus.cmd_valid     = 1'b1;
    cmd_bus.cmd_opcode    = OP_SPRITE_POS;
    cmd_bus.cmd_sprite_id = 5'd7;
    cmd_bus.cmd_x         = 10'd70;
    cmd_bus.cmd_y         = 10'd71;
    cmd_bus.cmd_aux       = 2'd1;
    chk("full cmd_ready", 32'(cmd_bus.cmd_ready), 0);
    repeat (3) @(negedge clk);
    chk("full held cmd_ready", 32'(cmd_bus.cmd_ready), 0);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    chk("full commit pulse", 32'(vsync_done), 1);
    chk("full ready during commit", 32'(cmd_bus.cmd_ready), 0);
    @(negedge clk);
    chk("ready after commit pop", 32'(cmd_bus.cmd_ready), 1);
    @(posedge clk);
    #1 cmd_bus.cmd_valid = 1'b0;
    commit("flush");
    rd_check("flush rd4", 5'd4, 10'd40, 10'd41, 1'b1, 2'd0);
    rd_check("flush rd6", 5'd6, 10'd60, 10'd61, 1'b1, 2'd0);
    rd_check("flush rd7", 5'd7, 10'd70, 10'd71, 1'b1, 2'd0);

    // Bad opcode and out-of-range ids
    chk("bad_cmd before", 32'(bad_cmd), 0);
    push(5'b00111, 5'd3, 10'd1, 10'd1, 2'd1);
    push(OP_SPRITE_POS, 5'd31, 10'd999, 10'd999, 2'd1);
    push(OP_SPRITE_LEVEL, 5'd20, 10'd0, 10'd0, 2'd3);
    commit("bad");
    chk("bad_cmd after", 32'(bad_cmd), 1);
    rd_check("bad rd15", 5'd15, 10'd1023, 10'd0, 1'b0, 2'd0);
    rd_check("bad rd3", 5'd3, 10'd200, 10'd300, 1'b1, 2'd2);
    rd_check("bad rd31", 5'd31, 10'd0, 10'd0, 1'b0, 2'd0);

    // Reset while waiting discards the pending commit
    push(OP_PUT_IMAGE, 5'd0, 10'd640, 10'd480, 2'd0);
    push(OP_WAIT_VSYNC, 5'd0, 10'd0, 10'd0, 2'd0);
    push(OP_SPRITE_POS, 5'd2, 10'd1, 10'd1, 2'd1);
    repeat (6) @(negedge clk);
    c0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    chk("async reset bg_x", 32'(bg_x), 0);
    chk("async reset bg_y", 32'(bg_y), 0);
    chk("async reset cmd_ready", 32'(cmd_bus.cmd_ready), 1);
    chk("async reset bad_cmd", 32'(bad_cmd), 0);
    chk("async reset vsync_done", 32'(vsync_done), 0);
    @(negedge clk);
    reset = 1'b0;
    pulse_vsync();
    repeat (5) @(negedge clk);
    chk("reset no vsync_done", 32'(done_cnt - c0), 0);
    chk("reset bg_x stays", 32'(bg_x), 0);
    chk("reset cmd_ready stays", 32'(cmd_bus.cmd_ready), 1);
    rd_check("reset rd3", 5'd3, 10'd0, 10'd0, 1'b0, 2'd0);
    rd_check("reset rd2", 5'd2, 10'd0, 10'd0, 1'b0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule
